// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate multiplier: mode encodings,
// error-accumulator width and the truncated-product reference function.
package approx_mul_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  localparam int ERR_W = 32;

  // Sum of all partial products x[i]&y[j] whose column i+j is >= trunc.
  // trunc = 0 gives the exact product. Operands up to 32 bits.
  function automatic logic [63:0] trunc_prod(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int          trunc);
    logic [63:0] t;
    t = '0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        if ((i + j) >= trunc) t = t + (64'(a[i] & b[j]) << (i + j));
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/approx_mul_core.sv
// Combinational partial-product column generation. Each output column
// holds the count of set partial products of that weight; in approximate
// mode the low TRUNC columns are forced empty.
module approx_mul_core
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 6,
  parameter int CW    = 4
) (
  input  logic [WIDTH-1:0]               x_i,
  input  logic [WIDTH-1:0]               y_i,
  input  logic                           mode_i,
  output logic [2*WIDTH-2:0][CW-1:0]     cols_o,
  output logic                           zero_o
);

  // Column popcounts of the AND array, with low columns masked when approximating
  always_comb begin
    cols_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (mode_i == MODE_EXACT || (i + j) >= TRUNC)
          cols_o[i+j] = cols_o[i+j] + CW'(x_i[i] & y_i[j]);
      end
    end
  end

  // Either operand zero forces a zero result, overriding the bias
  assign zero_o = (x_i == '0) || (y_i == '0);

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined exact/approximate unsigned multiplier with valid/ready on both
// sides. Stage 1 registers the column sums, the last stage registers z;
// a stall freezes the whole pipe. Optional error statistics are built
// when APPROX_MUL_ERR_STAT_EN is defined.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int TRUNC  = 6,
  parameter int BIAS   = 32,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z
`ifdef APPROX_MUL_ERR_STAT_EN
  ,
  input  logic               err_clr,
  output logic [ERR_W-1:0]   err_acc
`endif
);

  localparam int ZW   = 2 * WIDTH;
  localparam int NCOL = 2 * WIDTH - 1;
  localparam int CW   = $clog2(WIDTH + 1);

  logic                       en;
  logic [STAGES:1]            vld_pipe_q;
  logic [STAGES:0]            vld_sh;

  logic [NCOL-1:0][CW-1:0]    core_cols;
  logic                       core_zero;

  // Inputs to the final (z) register, from the core or the last column stage
  logic [NCOL-1:0][CW-1:0]    fin_cols;
  logic                       fin_mode;
  logic                       fin_zero;
  logic                       fin_vld;

  logic [ZW-1:0]              t_sum;
  logic [ZW-1:0]              z_d;
  logic [ZW-1:0]              z_q;

`ifdef APPROX_MUL_ERR_STAT_EN
  logic [ZW-1:0]              ex_in;
  logic [ZW-1:0]              fin_ex;
  logic [ZW-1:0]              ex_o_q;
  logic                       mode_o_q;
`endif

  assign out_valid = vld_pipe_q[STAGES];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign z         = z_q;

  approx_mul_core #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC),
    .CW    (CW)
  ) u_core (
    .x_i    (x),
    .y_i    (y),
    .mode_i (mode),
    .cols_o (core_cols),
    .zero_o (core_zero)
  );

`ifdef APPROX_MUL_ERR_STAT_EN
  assign ex_in = ZW'(trunc_prod(32'(x), 32'(y), 0));
`endif

  // Valid bits shift as one word whenever the pipe advances
  assign vld_sh = {vld_pipe_q, in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_pipe_q <= '0;
    else if (en) vld_pipe_q <= vld_sh[STAGES-1:0];
  end

  if (STAGES == 1) begin : g_one
    assign fin_cols = core_cols;
    assign fin_mode = mode;
    assign fin_zero = core_zero;
    assign fin_vld  = in_valid;
`ifdef APPROX_MUL_ERR_STAT_EN
    assign fin_ex   = ex_in;
`endif
  end else begin : g_multi
    logic [NCOL-1:0][CW-1:0] cols_q [1:STAGES-1];
    logic                    mode_q [1:STAGES-1];
    logic                    zero_q [1:STAGES-1];
`ifdef APPROX_MUL_ERR_STAT_EN
    logic [ZW-1:0]           ex_q   [1:STAGES-1];
`endif

    // Column-sum stages: stage 1 captures the core, later stages delay it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 1; s < STAGES; s++) begin
          cols_q[s] <= '0;
          mode_q[s] <= MODE_EXACT;
          zero_q[s] <= 1'b0;
`ifdef APPROX_MUL_ERR_STAT_EN
          ex_q[s]   <= '0;
`endif
        end
      end else if (en) begin
        if (in_valid) begin
          cols_q[1] <= core_cols;
          mode_q[1] <= mode;
          zero_q[1] <= core_zero;
`ifdef APPROX_MUL_ERR_STAT_EN
          ex_q[1]   <= ex_in;
`endif
        end
        for (int s = 2; s < STAGES; s++) begin
          if (vld_pipe_q[s-1]) begin
            cols_q[s] <= cols_q[s-1];
            mode_q[s] <= mode_q[s-1];
            zero_q[s] <= zero_q[s-1];
`ifdef APPROX_MUL_ERR_STAT_EN
            ex_q[s]   <= ex_q[s-1];
`endif
          end
        end
      end
    end

    assign fin_cols = cols_q[STAGES-1];
    assign fin_mode = mode_q[STAGES-1];
    assign fin_zero = zero_q[STAGES-1];
    assign fin_vld  = vld_pipe_q[STAGES-1];
`ifdef APPROX_MUL_ERR_STAT_EN
    assign fin_ex   = ex_q[STAGES-1];
`endif
  end

  // Weighted column reduction, then bias unless an operand was zero
  always_comb begin
    t_sum = '0;
    for (int k = 0; k < NCOL; k++) t_sum = t_sum + (ZW'(fin_cols[k]) << k);
    z_d = t_sum;
    if (fin_mode == MODE_APPROX && !fin_zero) z_d = t_sum + ZW'(BIAS);
  end

  // Result register; holds the last result across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             z_q <= '0;
    else if (en && fin_vld) z_q <= z_d;
  end

`ifdef APPROX_MUL_ERR_STAT_EN
  localparam int SW = ((ZW > ERR_W) ? ZW : ERR_W) + 1;

  logic [ERR_W-1:0] err_acc_q;
  logic [ERR_W-1:0] err_acc_d;
  logic [ZW-1:0]    diff;
  logic [SW-1:0]    sum;

  // Exact product and mode travel alongside z for the error statistic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_o_q   <= '0;
      mode_o_q <= MODE_EXACT;
    end else if (en && fin_vld) begin
      ex_o_q   <= fin_ex;
      mode_o_q <= fin_mode;
    end
  end

  // Saturating |exact - z| accumulation on approximate output transfers
  always_comb begin
    diff      = (ex_o_q >= z_q) ? (ex_o_q - z_q) : (z_q - ex_o_q);
    sum       = SW'(err_acc_q) + SW'(diff);
    err_acc_d = err_acc_q;
    if (err_clr)
      err_acc_d = '0;
    else if (out_valid && out_ready && mode_o_q == MODE_APPROX)
      err_acc_d = (sum > SW'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_acc_q <= '0;
    else        err_acc_q <= err_acc_d;
  end

  assign err_acc = err_acc_q;
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe at default parameters: directed
// vector table, streaming, backpressure, mid-flight reset and a random
// phase scored against a queue-based reference model.
module tb_approx_mul_pipe;
  import approx_mul_pkg::*;

  localparam int WIDTH  = 8;
  localparam int TRUNC  = 6;
  localparam int BIAS   = 32;
  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
`ifdef APPROX_MUL_ERR_STAT_EN
  logic        err_clr;
  logic [31:0] err_acc;
`endif

  always #5 clk = ~clk;

  approx_mul_pipe #(
    .WIDTH  (WIDTH),
    .TRUNC  (TRUNC),
    .BIAS   (BIAS),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
`ifdef APPROX_MUL_ERR_STAT_EN
    ,
    .err_clr   (err_clr),
    .err_acc   (err_acc)
`endif
  );

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        m;
    logic [15:0] z;
    longint      err;
  } vec_t;

  typedef struct {
    logic [15:0] z;
    logic [15:0] ex;
    logic        m;
  } exp_t;

  int     tests = 0;
  int     fails = 0;
  exp_t   q[$];
  longint mdl_err = 0;
  vec_t   vecs[9];

  // Reference: plain product, or kept partial products plus bias
  function automatic logic [15:0] ref_z(input logic [7:0] a, input logic [7:0] b,
                                        input logic m);
    logic [63:0] t;
    if (m == MODE_EXACT) return 16'(a) * 16'(b);
    if (a == 8'd0 || b == 8'd0) return 16'd0;
    t = trunc_prod(32'(a), 32'(b), TRUNC) + 64'(BIAS);
    return t[15:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: predicts on accepted inputs, checks consumed outputs
  task automatic monitor();
    exp_t e;
`ifdef APPROX_MUL_ERR_STAT_EN
    longint d;
`endif
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        mdl_err = 0;
      end else begin
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
`ifdef APPROX_MUL_ERR_STAT_EN
        chk("err_acc_track", err_acc, mdl_err);
`endif
        if (out_valid && out_ready) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL spurious_out: got z=%0d, expected no output", z);
          end else begin
            e = q.pop_front();
            if (z !== e.z) begin
              fails++;
              $display("FAIL z_stream: got %0d, expected %0d", z, e.z);
            end
`ifdef APPROX_MUL_ERR_STAT_EN
            if (e.m == MODE_APPROX) begin
              d = (e.ex >= e.z) ? longint'(e.ex - e.z) : longint'(e.z - e.ex);
              mdl_err = mdl_err + d;
              if (mdl_err > 64'hFFFF_FFFF) mdl_err = 64'hFFFF_FFFF;
            end
`endif
          end
        end
`ifdef APPROX_MUL_ERR_STAT_EN
        if (err_clr) mdl_err = 0;
`endif
        if (in_valid && in_ready) begin
          e.z  = ref_z(x, y, mode);
          e.ex = 16'(x) * 16'(y);
          e.m  = mode;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    x = v.x; y = v.y; mode = v.m; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("vec_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk($sformatf("vec%0d_latency", idx), lat, STAGES);
    chk($sformatf("vec%0d_z", idx), z, v.z);
    @(posedge clk); #1;
`ifdef APPROX_MUL_ERR_STAT_EN
    chk($sformatf("vec%0d_err_acc", idx), err_acc, v.err);
`endif
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first, last, cnt;
    logic [15:0] ea;

    vecs[0] = '{8'd255, 8'd255, 1'b1, 16'd64736, 289};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 16'd65025, 289};
    vecs[2] = '{8'd3,   8'd5,   1'b1, 16'd32,    306};
    vecs[3] = '{8'd0,   8'd200, 1'b1, 16'd0,     306};
    vecs[4] = '{8'd64,  8'd1,   1'b1, 16'd96,    338};
    vecs[5] = '{8'd1,   8'd64,  1'b1, 16'd96,    370};
    vecs[6] = '{8'd0,   8'd0,   1'b0, 16'd0,     370};
    vecs[7] = '{8'd128, 8'd128, 1'b1, 16'd16416, 402};
    vecs[8] = '{8'd255, 8'd1,   1'b1, 16'd224,   433};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; mode = 1'b0;
`ifdef APPROX_MUL_ERR_STAT_EN
    err_clr = 1'b0;
`endif
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_z", z, 0);
`ifdef APPROX_MUL_ERR_STAT_EN
    chk("reset_err_acc", err_acc, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    // Directed vectors
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Back-to-back stream of 8 mixed-mode transactions
    first = -1; last = -1; cnt = 0;
    fork
      begin
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
          x = 8'($urandom); y = 8'($urandom); mode = 1'(i % 3 != 0);
          in_valid = 1'b1;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 16; n++) begin
          @(negedge clk);
          if (out_valid) begin
            if (first < 0) first = n;
            last = n;
            cnt++;
          end
        end
      end
    join
    chk("stream_count", cnt, 8);
    chk("stream_contiguous", last - first + 1, 8);
    drain();

    // Backpressure with a full pipe
    @(posedge clk); #1;
    out_ready = 1'b0;
    x = 8'd200; y = 8'd77; mode = 1'b1; in_valid = 1'b1;
    ea = ref_z(8'd200, 8'd77, 1'b1);
    @(posedge clk); #1;
    x = 8'd13; y = 8'd250; mode = 1'b0;
    @(posedge clk); #1;
    x = 8'd99; y = 8'd99; mode = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_z_held", z, ea);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      x = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      y = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom);
      mode = 1'($urandom_range(0, 1));
`ifdef APPROX_MUL_ERR_STAT_EN
      err_clr = ($urandom_range(0, 49) == 0);
`endif
    end
`ifdef APPROX_MUL_ERR_STAT_EN
    @(posedge clk); #1;
    err_clr = 1'b0;
`endif
    drain();

    // Reset with two transactions in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    x = 8'd17; y = 8'd19; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    x = 8'd250; y = 8'd3; mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_z", z, 0);
`ifdef APPROX_MUL_ERR_STAT_EN
    chk("midrst_err_acc", err_acc, 0);
`endif
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("post_reset_no_output", out_valid, 0);
    end
    chk("post_reset_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
